// File: rtl/level_generator_if.sv
// Control/data bundle between the game controller, the level generator and
// the playback/response stages.
interface level_generator_if;
    logic        new_game;
    logic        advance;
    logic [15:0] level_data;
    logic [3:0]  level_length;
    logic        level_ready;
    logic        game_complete;

    modport master (
        output new_game,
        output advance,
        input  level_data,
        input  level_length,
        input  level_ready,
        input  game_complete
    );

    modport slave (
        input  new_game,
        input  advance,
        output level_data,
        output level_length,
        output level_ready,
        output game_complete
    );
endinterface

// File: rtl/level_generator.sv
// Builds the memory-game note sequence: one pseudo-random one-hot note is
// appended per won level, earlier notes are never touched.
module level_generator #(
    parameter int          MAX_NOTES = 4,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    level_generator_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GEN      = 2'd1,
        S_READY    = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    localparam logic [3:0]  MAX_LEN  = 4'(MAX_NOTES);
    localparam logic [15:0] TAP_MASK = 16'hB400;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_lfsr;
    logic [15:0] r_level_data;
    logic [3:0]  r_level_length;
    logic        r_level_ready;
    logic        r_game_complete;

    logic [15:0] w_level_data;
    logic [3:0]  w_level_length;
    logic        w_level_ready;
    logic        w_game_complete;
    logic [3:0]  w_candidate;
    logic [3:0]  w_prev_note;
    logic [3:0]  w_note;

    // Galois right-shift step; an all-zero register is forced back to 1 so
    // the generator can never lock up.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'h0000) begin
            r = 16'h0001;
        end else if (v[0]) begin
            r = (v >> 1) ^ TAP_MASK;
        end else begin
            r = v >> 1;
        end
        return r;
    endfunction

    function automatic logic [3:0] get_nibble(input logic [15:0] data, input logic [1:0] idx);
        logic [3:0] r;
        case (idx)
            2'd0:    r = data[15:12];
            2'd1:    r = data[11:8];
            2'd2:    r = data[7:4];
            2'd3:    r = data[3:0];
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] set_nibble(input logic [15:0] data, input logic [1:0] idx,
                                               input logic [3:0] note);
        logic [15:0] r;
        r = data;
        case (idx)
            2'd0:    r[15:12] = note;
            2'd1:    r[11:8]  = note;
            2'd2:    r[7:4]   = note;
            2'd3:    r[3:0]   = note;
            default: r = data;
        endcase
        return r;
    endfunction

    assign w_candidate = 4'b0001 << r_lfsr[1:0];
    assign w_prev_note = get_nibble(r_level_data, r_level_length[1:0] - 2'd1);
    assign w_note      = ((r_level_length != 4'd0) && (w_candidate == w_prev_note))
                         ? {w_candidate[2:0], w_candidate[3]} : w_candidate;

    // Free-running note source, independent of game flow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_level_data    <= 16'h0000;
            r_level_length  <= 4'd0;
            r_level_ready   <= 1'b0;
            r_game_complete <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_level_data    <= w_level_data;
            r_level_length  <= w_level_length;
            r_level_ready   <= w_level_ready;
            r_game_complete <= w_game_complete;
        end
    end

    // Next-state and next-output logic; new_game wins over everything.
    always_comb begin
        w_next_state    = r_state;
        w_level_data    = r_level_data;
        w_level_length  = r_level_length;
        w_level_ready   = r_level_ready;
        w_game_complete = r_game_complete;

        if (bus.new_game) begin
            w_next_state    = S_GEN;
            w_level_data    = 16'h0000;
            w_level_length  = 4'd0;
            w_level_ready   = 1'b0;
            w_game_complete = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next_state = S_IDLE;
                end
                S_GEN: begin
                    w_level_data   = set_nibble(r_level_data, r_level_length[1:0], w_note);
                    w_level_length = r_level_length + 4'd1;
                    w_level_ready  = 1'b1;
                    w_next_state   = S_READY;
                end
                S_READY: begin
                    if (bus.advance) begin
                        w_level_ready = 1'b0;
                        if (r_level_length < MAX_LEN) begin
                            w_next_state = S_GEN;
                        end else begin
                            w_next_state    = S_COMPLETE;
                            w_game_complete = 1'b1;
                        end
                    end else begin
                        w_next_state = S_READY;
                    end
                end
                S_COMPLETE: begin
                    w_next_state = S_COMPLETE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    assign bus.level_data    = r_level_data;
    assign bus.level_length  = r_level_length;
    assign bus.level_ready   = r_level_ready;
    assign bus.game_complete = r_game_complete;

endmodule

// File: tb/tb_level_generator.sv
// Directed bench for level_generator: stimulus pushes expected levels into a
// queue, a monitor pops and compares on each rising level_ready.
module tb_level_generator;

    logic clk;
    logic reset;

    level_generator_if bus_if ();

    level_generator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic [3:0]  len;
        logic [15:0] data;
        logic [15:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where level_ready is seen.
    task automatic wait_ready(output int lows);
        bit got;
        got  = 1'b0;
        lows = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus_if.level_ready) begin
                got = 1'b1;
            end else begin
                lows++;
                @(negedge clk);
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: level_ready never rose within 20 cycles");
        end
    endtask

    task automatic pulse(input bit ng, input bit adv, output int lows);
        bus_if.new_game = ng;
        bus_if.advance  = adv;
        @(negedge clk);
        bus_if.new_game = 1'b0;
        bus_if.advance  = 1'b0;
        wait_ready(lows);
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        bit   prev_ready;
        bit   ok;
        logic [3:0] nib;
        logic [3:0] prev_nib;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ready = 1'b0;
            end else begin
                if (bus_if.level_ready && !prev_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_level: length %0d data %0h with nothing expected",
                                 bus_if.level_length, bus_if.level_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_level_length", 32'(bus_if.level_length), 32'(e.len));
                        check("sb_level_data", 32'(bus_if.level_data & e.mask), 32'(e.data & e.mask));
                        ok = 1'b1;
                        prev_nib = 4'b0000;
                        for (int i = 0; i < 4; i++) begin
                            nib = bus_if.level_data[15 - 4*i -: 4];
                            if (i < int'(bus_if.level_length)) begin
                                if ($countones(nib) != 1) ok = 1'b0;
                                if (i > 0 && nib == prev_nib) ok = 1'b0;
                            end else if (nib != 4'b0000) begin
                                ok = 1'b0;
                            end
                            prev_nib = nib;
                        end
                        check("sb_note_structure", 32'(ok), 32'd1);
                    end
                end
                prev_ready = bus_if.level_ready;
            end
        end
    end

    // Stimulus.
    initial begin
        int lows;
        bus_if.new_game = 1'b0;
        bus_if.advance  = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_level_data", 32'(bus_if.level_data), 32'h0);
        check("reset_level_length", 32'(bus_if.level_length), 32'h0);
        check("reset_level_ready", 32'(bus_if.level_ready), 32'h0);
        check("reset_game_complete", 32'(bus_if.game_complete), 32'h0);

        // advance while idle is ignored
        reset = 1'b0;
        bus_if.advance = 1'b1;
        @(negedge clk);
        bus_if.advance = 1'b0;
        @(negedge clk);
        check("idle_adv_length", 32'(bus_if.level_length), 32'h0);
        check("idle_adv_ready", 32'(bus_if.level_ready), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // level 1 straight after reset release: lfsr E270 at GEN -> note 0001
        reset = 1'b0;
        exp_q.push_back('{len: 4'd1, data: 16'h1000, mask: 16'hFFFF});
        pulse(1'b1, 1'b0, lows);

        // three advances: lfsr 389C (0001 repeat -> 0010), 0E27 -> 1000, ED89 -> 0010
        exp_q.push_back('{len: 4'd2, data: 16'h1200, mask: 16'hFFFF});
        pulse(1'b0, 1'b1, lows);
        check("adv1_ready_low_cycles", 32'(lows), 32'd1);
        exp_q.push_back('{len: 4'd3, data: 16'h1280, mask: 16'hFFFF});
        pulse(1'b0, 1'b1, lows);
        check("adv2_ready_low_cycles", 32'(lows), 32'd1);
        exp_q.push_back('{len: 4'd4, data: 16'h1282, mask: 16'hFFFF});
        pulse(1'b0, 1'b1, lows);
        check("adv3_ready_low_cycles", 32'(lows), 32'd1);

        // winning the full-length level
        bus_if.advance = 1'b1;
        @(negedge clk);
        bus_if.advance = 1'b0;
        check("complete_flag", 32'(bus_if.game_complete), 32'h1);
        check("complete_ready", 32'(bus_if.level_ready), 32'h0);
        check("complete_data", 32'(bus_if.level_data), 32'h1282);
        check("complete_length", 32'(bus_if.level_length), 32'h4);
        repeat (2) begin
            bus_if.advance = 1'b1;
            @(negedge clk);
            bus_if.advance = 1'b0;
            @(negedge clk);
        end
        check("complete_hold_flag", 32'(bus_if.game_complete), 32'h1);
        check("complete_hold_data", 32'(bus_if.level_data), 32'h1282);
        check("complete_hold_length", 32'(bus_if.level_length), 32'h4);
        check("complete_hold_ready", 32'(bus_if.level_ready), 32'h0);

        // new_game with advance from COMPLETE; advance also held through GEN
        exp_q.push_back('{len: 4'd1, data: 16'h0000, mask: 16'h0FFF});
        bus_if.new_game = 1'b1;
        bus_if.advance  = 1'b1;
        @(negedge clk);
        bus_if.new_game = 1'b0;
        check("restart_complete_cleared", 32'(bus_if.game_complete), 32'h0);
        check("restart_ready_low", 32'(bus_if.level_ready), 32'h0);
        check("restart_length_zero", 32'(bus_if.level_length), 32'h0);
        check("restart_data_zero", 32'(bus_if.level_data), 32'h0);
        @(negedge clk);
        bus_if.advance = 1'b0;
        check("gen_adv_ignored_length", 32'(bus_if.level_length), 32'h1);
        @(negedge clk);
        check("gen_adv_ignored_hold", 32'(bus_if.level_length), 32'h1);
        check("gen_adv_ignored_ready", 32'(bus_if.level_ready), 32'h1);

        // one accepted advance adds exactly one note
        exp_q.push_back('{len: 4'd2, data: 16'h0000, mask: 16'h00FF});
        pulse(1'b0, 1'b1, lows);
        check("adv4_ready_low_cycles", 32'(lows), 32'd1);

        // reset while in GEN at length 2
        bus_if.advance = 1'b1;
        @(posedge clk);
        #2;
        bus_if.advance = 1'b0;
        reset = 1'b1;
        #1;
        check("midgen_reset_data", 32'(bus_if.level_data), 32'h0);
        check("midgen_reset_length", 32'(bus_if.level_length), 32'h0);
        check("midgen_reset_ready", 32'(bus_if.level_ready), 32'h0);
        check("midgen_reset_complete", 32'(bus_if.game_complete), 32'h0);
        repeat (2) @(negedge clk);

        // LFSR restarts from SEED: first level reproduces 1000
        reset = 1'b0;
        exp_q.push_back('{len: 4'd1, data: 16'h1000, mask: 16'hFFFF});
        pulse(1'b1, 1'b0, lows);
        @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
